// File: rtl/display_7seg_scroll.sv
// Multiplexed 7-segment driver showing a blank, static, blinking or scrolling message.
// seg/an are registered from the digit index; a mode change restarts scroll and blink.
module display_7seg_scroll #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 50000000,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  msg_wrap
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int RW = $clog2(SCROLL_DIV);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_TC   = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC  = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] SCROLL_TC = RW'(SCROLL_DIV - 1);

  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [BW-1:0]         blink_q, blink_d;
  logic [RW-1:0]         scroll_q, scroll_d;
  logic [3:0]            pos_q, pos_d;
  logic                  hidden_q, hidden_d;
  logic [1:0]            mode_q, mode_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  wrap_q, wrap_d;

  function automatic logic [6:0] heat_glyph(input int i);
    case (i)
      0:       return 7'h07;
      1:       return 7'h08;
      2:       return 7'h06;
      3:       return 7'h09;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] done_glyph(input int i);
    case (i)
      0:       return 7'h06;
      1:       return 7'h2B;
      2:       return 7'h23;
      3:       return 7'h21;
      default: return 7'h7F;
    endcase
  endfunction

  // Message "door OPEn "; i may run up to 16, so fold once into 0..9.
  function automatic logic [6:0] scroll_glyph(input int i);
    int j;
    j = (i >= 10) ? i - 10 : i;
    case (j)
      0:       return 7'h21;
      1, 2:    return 7'h23;
      3:       return 7'h2F;
      5:       return 7'h40;
      6:       return 7'h0C;
      7:       return 7'h06;
      8:       return 7'h2B;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    logic       mode_chg;
    logic [3:0] pos_eff;
    logic       hid_eff;
    int         k;

    mode_chg = (mode != mode_q);
    // A fresh mode is shown from its start immediately, not one cycle late.
    pos_eff  = mode_chg ? 4'd0 : pos_q;
    hid_eff  = mode_chg ? 1'b0 : hidden_q;
    k        = (NUM_DIGITS - 1) - int'(idx_q);

    case (mode)
      2'b01:   seg_d = heat_glyph(int'(idx_q));
      2'b10:   seg_d = hid_eff ? 7'h7F : done_glyph(int'(idx_q));
      2'b11:   seg_d = scroll_glyph(int'(pos_eff) + k);
      default: seg_d = 7'h7F;
    endcase

    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (idx_q != IW'(i));
    end

    idx_d  = idx_q;
    scan_d = scan_q + 1'b1;
    if (scan_q == SCAN_TC) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    blink_d  = '0;
    hidden_d = hidden_q;
    scroll_d = '0;
    pos_d    = pos_q;
    wrap_d   = 1'b0;
    mode_d   = mode;
    if (mode_chg) begin
      hidden_d = 1'b0;
      pos_d    = 4'd0;
    end else begin
      if (mode == 2'b10) begin
        blink_d = blink_q + 1'b1;
        if (blink_q == BLINK_TC) begin
          blink_d  = '0;
          hidden_d = ~hidden_q;
        end
      end
      if (mode == 2'b11) begin
        scroll_d = scroll_q + 1'b1;
        if (scroll_q == SCROLL_TC) begin
          scroll_d = '0;
          pos_d    = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
          wrap_d   = (pos_q == 4'd9);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      scan_q   <= '0;
      blink_q  <= '0;
      scroll_q <= '0;
      pos_q    <= 4'd0;
      hidden_q <= 1'b0;
      mode_q   <= 2'b00;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      wrap_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      blink_q  <= blink_d;
      scroll_q <= scroll_d;
      pos_q    <= pos_d;
      hidden_q <= hidden_d;
      mode_q   <= mode_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      wrap_q   <= wrap_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = 1'b1;
  assign msg_wrap = wrap_q;

endmodule

// File: tb/tb_display_7seg_scroll.sv
// Scoreboard bench: a reference model predicts outputs of a 4-digit and a 6-digit instance each edge.
module tb_display_7seg_scroll;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [6:0] seg4, seg6;
  logic [3:0] an4;
  logic [5:0] an6;
  logic       dp4, dp6, wrap4, wrap6;

  always #5 clk = ~clk;

  display_7seg_scroll #(.NUM_DIGITS(4), .SCAN_DIV(2), .BLINK_DIV(8), .SCROLL_DIV(16)) u_dut4 (
    .clk(clk), .reset(reset), .mode(mode), .seg(seg4), .an(an4), .dp(dp4), .msg_wrap(wrap4));

  display_7seg_scroll #(.NUM_DIGITS(6), .SCAN_DIV(2), .BLINK_DIV(8), .SCROLL_DIV(16)) u_dut6 (
    .clk(clk), .reset(reset), .mode(mode), .seg(seg6), .an(an6), .dp(dp6), .msg_wrap(wrap6));

  typedef struct {
    logic [6:0] seg;
    logic [7:0] an;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wraps    = 0;

  logic [6:0] heat_w [4]  = '{7'h09, 7'h06, 7'h08, 7'h07};
  logic [6:0] done_w [4]  = '{7'h21, 7'h23, 7'h2B, 7'h06};
  logic [6:0] msg_w  [10] = '{7'h21, 7'h23, 7'h23, 7'h2F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B, 7'h7F};

  // Reference state per instance (0: 4 digits, 1: 6 digits).
  int   ndig  [2] = '{4, 6};
  int   m_idx [2] = '{0, 0};
  int   m_scan[2] = '{0, 0};
  int   m_blk [2] = '{0, 0};
  int   m_hid [2] = '{0, 0};
  int   m_scr [2] = '{0, 0};
  int   m_pos [2] = '{0, 0};
  int   m_mode[2] = '{0, 0};

  logic [6:0] win4[4];
  logic [6:0] win6[6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] word_glyph(input int n, input int m, input int k, input int pe, input int he);
    int j;
    j = k - (n - 4);
    case (m)
      1:       return (j < 0) ? 7'h7F : heat_w[j];
      2:       return (he != 0 || j < 0) ? 7'h7F : done_w[j];
      3:       return msg_w[(pe + k) % 10];
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_edge(input int s, input logic r, input logic [1:0] m);
    exp_t e;
    int   chg, pe, he, n;
    n = ndig[s];
    if (r) begin
      e.seg = 7'h7F; e.an = 8'h00; e.wrap = 1'b0;
      for (int i = 0; i < n; i++) e.an[i] = 1'b1;
      m_idx[s] = 0; m_scan[s] = 0; m_blk[s] = 0; m_hid[s] = 0;
      m_scr[s] = 0; m_pos[s] = 0; m_mode[s] = 0;
    end else begin
      chg = (int'(m) != m_mode[s]) ? 1 : 0;
      pe  = chg ? 0 : m_pos[s];
      he  = chg ? 0 : m_hid[s];
      e.an = 8'h00;
      for (int i = 0; i < n; i++) e.an[i] = (i != m_idx[s]);
      e.seg  = word_glyph(n, int'(m), n - 1 - m_idx[s], pe, he);
      e.wrap = (!chg && m == 2'b11 && m_scr[s] == 15 && m_pos[s] == 9);
      if (m_scan[s] == 1) begin
        m_scan[s] = 0;
        m_idx[s]  = (m_idx[s] + 1) % n;
      end else m_scan[s]++;
      if (chg) begin
        m_blk[s] = 0; m_hid[s] = 0; m_scr[s] = 0; m_pos[s] = 0;
      end else begin
        if (m == 2'b10) begin
          if (m_blk[s] == 7) begin m_blk[s] = 0; m_hid[s] = 1 - m_hid[s]; end
          else m_blk[s]++;
        end else m_blk[s] = 0;
        if (m == 2'b11) begin
          if (m_scr[s] == 15) begin m_scr[s] = 0; m_pos[s] = (m_pos[s] + 1) % 10; end
          else m_scr[s]++;
        end else m_scr[s] = 0;
      end
      m_mode[s] = int'(m);
    end
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: drive, predict, take the rising edge, compare.
  task automatic step(input logic r, input logic [1:0] m);
    exp_t e;
    reset = r;
    mode  = m;
    model_edge(0, r, m);
    model_edge(1, r, m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("seg4", seg4, e.seg);
    chk("an4", {4'h0, an4}, e.an);
    chk("wrap4", wrap4, e.wrap);
    chk("dp4", dp4, 1'b1);
    e = exp_q.pop_front();
    chk("seg6", seg6, e.seg);
    chk("an6", {2'b00, an6}, e.an);
    chk("wrap6", wrap6, e.wrap);
    if (wrap4) wraps++;
    @(negedge clk);
  endtask

  function automatic int low_idx(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) if (!a[i]) return i;
    return 0;
  endfunction

  task automatic capture(input int n, input logic [1:0] m);
    for (int i = 0; i < 4; i++) win4[i] = 7'h55;
    for (int i = 0; i < 6; i++) win6[i] = 7'h55;
    repeat (n) begin
      step(1'b0, m);
      win4[low_idx({4'h0, an4}, 4)] = seg4;
      win6[low_idx({2'b00, an6}, 6)] = seg6;
    end
  endtask

  task automatic check_door(input string tag);
    chk({tag, "_d"}, win4[3], 7'h21);
    chk({tag, "_o"}, win4[2], 7'h23);
    chk({tag, "_o2"}, win4[1], 7'h23);
    chk({tag, "_r"}, win4[0], 7'h2F);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    repeat (3) step(1'b1, 2'b01);
    chk("rst_an", an4, 4'hF);
    chk("rst_seg", seg4, 7'h7F);
    chk("rst_wrap", wrap4, 1'b0);

    // Static "HEAt"
    step(1'b0, 2'b01);
    chk("rel_an", an4, 4'b1110);
    chk("rel_seg", seg4, 7'h07);
    capture(12, 2'b01);
    chk("heat_t", win4[0], 7'h07);
    chk("heat_A", win4[1], 7'h08);
    chk("heat_E", win4[2], 7'h06);
    chk("heat_H", win4[3], 7'h09);
    chk("heat6_4", win6[4], 7'h7F);
    chk("heat6_5", win6[5], 7'h7F);
    chk("heat6_H", win6[3], 7'h09);

    // Blinking "donE": visible for edges 1..9 of the mode, hidden for 10..17
    capture(8, 2'b10);
    chk("done_d", win4[3], 7'h21);
    chk("done_o", win4[2], 7'h23);
    chk("done_n", win4[1], 7'h2B);
    chk("done_E", win4[0], 7'h06);
    step(1'b0, 2'b10);
    capture(8, 2'b10);
    for (int i = 0; i < 4; i++) chk("blink_hidden", win4[i], 7'h7F);
    repeat (20) step(1'b0, 2'b10);

    // Scrolling
    wraps = 0;
    capture(12, 2'b11);
    check_door("door");
    chk("door6_space", win6[1], 7'h7F);
    chk("door6_O", win6[0], 7'h40);
    chk("door6_d", win6[5], 7'h21);
    repeat (6) step(1'b0, 2'b11);
    capture(8, 2'b11);
    chk("oor_o", win4[3], 7'h23);
    chk("oor_o2", win4[2], 7'h23);
    chk("oor_r", win4[1], 7'h2F);
    chk("oor_sp", win4[0], 7'h7F);
    repeat (174) step(1'b0, 2'b11);
    chk("wrap_count", wraps, 1);

    // Mode change at pos 5 restarts the message
    repeat (3) step(1'b0, 2'b10);
    repeat (90) step(1'b0, 2'b11);
    repeat (3) step(1'b0, 2'b10);
    capture(12, 2'b11);
    check_door("restart");

    // Reset mid-scroll at pos 7
    repeat (108) step(1'b0, 2'b11);
    wraps = 0;
    step(1'b1, 2'b11);
    chk("midrst_an", an4, 4'hF);
    chk("midrst_seg", seg4, 7'h7F);
    chk("midrst_wrap", wrap4, 1'b0);
    capture(12, 2'b11);
    check_door("after_rst");
    chk("rst_no_wrap", wraps, 0);

    repeat (10) step(1'b0, 2'b00);
    repeat (5) step(1'b0, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
